// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch bus handshake controller
// One outstanding request; stalled completions are parked in a holding buffer.
module inst_fetch_ctrl #(
   parameter int ALIGN_CHECK = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   input  logic        stallF_pipe,
   input  logic        flush_req,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] instrF,
   output logic        instr_valid,
   output logic        fetch_adel,
   output logic        stall_fetch
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        discard_q, discard_d;
   logic [31:0] buf_q, buf_d;
   logic        misaligned;

   assign misaligned = (ALIGN_CHECK != 0) && (pcF[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      buf_d       = buf_q;
      inst_req    = 1'b0;
      inst_addr   = 32'h0;
      instrF      = 32'h0;
      instr_valid = 1'b0;
      fetch_adel  = 1'b0;
      stall_fetch = 1'b1;

      case (state_q)
         S_IDLE: begin
            state_d = S_ADDR;
         end
         S_ADDR: begin
            if (misaligned) begin
               // Address error is reported in place of an instruction; wait for a redirect.
               instr_valid = !flush_req;
               fetch_adel  = !flush_req;
               stall_fetch = stallF_pipe;
            end else begin
               inst_req  = 1'b1;
               inst_addr = pcF;
               if (inst_addr_ok) begin
                  state_d   = S_DATA;
                  discard_d = flush_req;
               end
            end
         end
         S_DATA: begin
            if (inst_data_ok) begin
               discard_d = 1'b0;
               if (discard_q || flush_req) begin
                  state_d = S_ADDR;
               end else if (stallF_pipe) begin
                  buf_d   = inst_rdata;
                  state_d = S_HOLD;
               end else begin
                  instrF      = inst_rdata;
                  instr_valid = 1'b1;
                  stall_fetch = 1'b0;
                  state_d     = S_ADDR;
               end
            end else if (flush_req) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush_req) begin
               buf_d   = 32'h0;
               state_d = S_ADDR;
            end else begin
               instrF      = buf_q;
               instr_valid = 1'b1;
               stall_fetch = stallF_pipe;
               if (!stallF_pipe) begin
                  state_d = S_ADDR;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Drop the bus request immediately while reset is held.
      if (rst) begin
         inst_req    = 1'b0;
         inst_addr   = 32'h0;
         instrF      = 32'h0;
         instr_valid = 1'b0;
         fetch_adel  = 1'b0;
         stall_fetch = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         discard_q <= 1'b0;
         buf_q     <= 32'h0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         buf_q     <= buf_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl
// Drives ALIGN_CHECK=0 and ALIGN_CHECK=1 instances with the same stimulus.
module tb_inst_fetch_ctrl;

   localparam logic lo = 1'b0;
   localparam logic hi = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pcF = 32'h0;
   logic        stallF_pipe = 1'b0;
   logic        flush_req = 1'b0;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'h0;

   logic        req0, valid0, adel0, stall0;
   logic [31:0] addr0, instr0;
   logic        req1, valid1, adel1, stall1;
   logic [31:0] addr1, instr1;

   always #5 clk = ~clk;

   inst_fetch_ctrl #(.ALIGN_CHECK(0)) dut0 (
      .clk(clk), .rst(rst), .pcF(pcF), .stallF_pipe(stallF_pipe), .flush_req(flush_req),
      .inst_req(req0), .inst_addr(addr0), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .instrF(instr0),
      .instr_valid(valid0), .fetch_adel(adel0), .stall_fetch(stall0)
   );

   inst_fetch_ctrl #(.ALIGN_CHECK(1)) dut1 (
      .clk(clk), .rst(rst), .pcF(pcF), .stallF_pipe(stallF_pipe), .flush_req(flush_req),
      .inst_req(req1), .inst_addr(addr1), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .instrF(instr1),
      .instr_valid(valid1), .fetch_adel(adel1), .stall_fetch(stall1)
   );

   typedef struct {
      int          cyc;
      logic        chk;
      logic        boot;
      logic        req;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        valid;
      logic        adel;
      logic        stall;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [31:0] pc = 32'h0;
   logic        m_boot[2];
   logic        m_busy[2];
   logic        m_stale[2];
   logic        m_held[2];
   logic [31:0] m_hbuf[2];

   task automatic chk(input string nm, input int id, input int c, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, id, c, got, exp);
      end
   endtask

   task automatic cmp_all(input int id, input exp_t e, input logic rq, input logic [31:0] ad,
                          input logic [31:0] ins, input logic vl, input logic ae,
                          input logic st);
      if (e.chk) begin
         chk("inst_req", id, e.cyc, {31'b0, rq}, {31'b0, e.req});
         if (e.req || e.boot) chk("inst_addr", id, e.cyc, ad, e.addr);
         chk("instrF", id, e.cyc, ins, e.instr);
         chk("instr_valid", id, e.cyc, {31'b0, vl}, {31'b0, e.valid});
         chk("fetch_adel", id, e.cyc, {31'b0, ae}, {31'b0, e.adel});
         chk("stall_fetch", id, e.cyc, {31'b0, st}, {31'b0, e.stall});
      end
   endtask

   // Monitor: every cycle the DUTs present outputs, compare with the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp_all(0, e, req0, addr0, instr0, valid0, adel0, stall0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         cmp_all(1, e, req1, addr1, instr1, valid1, adel1, stall1);
      end
   end

   // Reference: tracks "booting", "request in flight", "in-flight data is stale" and a
   // parked instruction, and derives each cycle's outputs from those facts.
   task automatic step(input logic r, input logic s, input logic f, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic [31:0] npc);
      exp_t e;
      logic adv;
      @(posedge clk);
      #1;
      cyc++;
      if (r || f) pc = npc;
      rst          = r;
      stallF_pipe  = s;
      flush_req    = f;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      pcF          = pc;
      adv          = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e.cyc = cyc; e.chk = !r; e.boot = 1'b0; e.req = 1'b0; e.addr = 32'h0;
         e.instr = 32'h0; e.valid = 1'b0; e.adel = 1'b0; e.stall = 1'b1;
         if (r) begin
            m_boot[i] = 1'b1; m_busy[i] = 1'b0; m_stale[i] = 1'b0; m_held[i] = 1'b0;
         end else if (m_boot[i]) begin
            m_boot[i] = 1'b0;
            e.boot    = 1'b1;
         end else if (m_held[i]) begin
            if (f) m_held[i] = 1'b0;
            else begin
               e.valid = 1'b1; e.instr = m_hbuf[i]; e.stall = s;
               if (!s) m_held[i] = 1'b0;
            end
         end else if (m_busy[i]) begin
            if (dok) begin
               m_busy[i] = 1'b0;
               if (m_stale[i] || f) m_stale[i] = 1'b0;
               else if (s) begin
                  m_held[i] = 1'b1; m_hbuf[i] = rd;
               end else begin
                  e.valid = 1'b1; e.instr = rd; e.stall = 1'b0;
               end
            end else if (f) m_stale[i] = 1'b1;
         end else if (i == 1 && pc[1:0] != 2'b00) begin
            e.valid = !f; e.adel = !f; e.stall = s;
         end else begin
            e.req = 1'b1; e.addr = pc;
            if (aok) begin
               m_busy[i] = 1'b1; m_stale[i] = f;
            end
         end
         if (i == 0) q0.push_back(e);
         else begin
            q1.push_back(e);
            adv = !f && !r && !e.stall;
         end
      end
      if (adv) pc = pc + 32'd4;
   endtask

   initial begin
      logic [31:0] np;
      logic        r;
      // reset
      step(hi, lo, lo, lo, lo, 32'h0, 32'hBFC00000);
      step(hi, lo, lo, lo, lo, 32'h0, 32'hBFC00000);
      // plain fetch
      step(lo, lo, lo, lo, lo, 32'h0, 32'h0);
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h24080001, 32'h0);
      // stall at completion, then HOLD with a stray data_ok
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, hi, lo, lo, hi, 32'h8C020000, 32'h0);
      step(lo, hi, lo, lo, hi, 32'h0, 32'h0);
      step(lo, hi, lo, lo, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, lo, 32'h0, 32'h0);
      // flush while outstanding
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, hi, lo, lo, 32'h0, 32'hBFC00380);
      step(lo, lo, lo, lo, hi, 32'h11111111, 32'h0);
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h42000018, 32'h0);
      // slow slave
      repeat (5) step(lo, lo, lo, lo, lo, 32'h0, 32'h0);
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h00000013, 32'h0);
      // misaligned PC
      step(lo, hi, hi, lo, lo, 32'h0, 32'hBFC00002);
      step(lo, hi, lo, lo, lo, 32'h0, 32'h0);
      step(lo, hi, lo, lo, lo, 32'h0, 32'h0);
      step(lo, lo, hi, lo, lo, 32'h0, 32'hBFC00010);
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h00000001, 32'h0);
      // reset while data outstanding, late data_ok afterwards
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, lo, 32'h0, 32'h0);
      step(hi, lo, lo, lo, lo, 32'h0, 32'hBFC00000);
      step(lo, lo, lo, lo, hi, 32'h0000DEAD, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h0000BEEF, 32'h0);
      step(lo, lo, lo, hi, lo, 32'h0, 32'h0);
      step(lo, lo, lo, lo, hi, 32'h00000002, 32'h0);
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         np = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) np[1:0] = 2'($urandom_range(1, 3));
         r = ($urandom_range(0, 199) == 0);
         step(r, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, np);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                  q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
